// File: rtl/mesh_port_arbiter_if.sv
// rtl/mesh_port_arbiter_if.sv - handshake bundle between mesh inputs, arbiter and output link
//
// Signals:
//   in_valid/in_flit/in_ready : per-input flit offer and accept (NUM_IN lanes)
//   out_valid/out_flit        : registered output link flit
//   out_ready                 : downstream accept
//   grant_id/locked           : last granted input, packet-lock status
//   timeout_err               : one-cycle watchdog release pulse
interface mesh_port_arbiter_if #(
    parameter int NUM_IN = 5,
    parameter int FLIT_W = 64
);
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*FLIT_W-1:0] in_flit;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_ready;
    logic [2:0]               grant_id;
    logic                     locked;
    logic                     timeout_err;

    // Arbiter side.
    modport slave (
        input  in_valid, in_flit, out_ready,
        output in_ready, out_valid, out_flit, grant_id, locked, timeout_err
    );

    // Source/sink side.
    modport master (
        output in_valid, in_flit, out_ready,
        input  in_ready, out_valid, out_flit, grant_id, locked, timeout_err
    );
endinterface

// File: rtl/mesh_port_arbiter.sv
// rtl/mesh_port_arbiter.sv - round-robin output-port arbiter with packet lock and watchdog
//
// Ports:
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset
//   bus : mesh_port_arbiter_if.slave
//         in_valid/in_flit in, in_ready out (combinational, one-hot or zero)
//         out_valid/out_flit out (registered), out_ready in
//         grant_id, locked, timeout_err out (registered)
module mesh_port_arbiter #(
    parameter int NUM_IN   = 5,
    parameter int FLIT_W   = 64,
    parameter int LAST_BIT = 62,
    parameter int MAX_IDLE = 16
) (
    input  logic                clk,
    input  logic                rst,
    mesh_port_arbiter_if.slave  bus
);
    localparam int IDX_W  = 3;
    localparam int IDLE_W = $clog2(MAX_IDLE + 1);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic                locked_q, locked_d;
    logic                timeout_q, timeout_d;

    logic                space;
    logic                sel_valid;
    logic                xfer;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    cand;
    logic [FLIT_W-1:0]   sel_flit;
    logic [NUM_IN-1:0]   ready;

    // Explicit modulo-NUM_IN increment so the pointer never names a missing input.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_IN - 1)) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    // Winner selection: the owner while locked, otherwise the first valid
    // input at or after the round-robin pointer.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        cand      = ptr_q;
        if (state_q == ST_LOCKED) begin
            sel_idx   = owner_q;
            sel_valid = bus.in_valid[owner_q];
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (!sel_valid && bus.in_valid[cand]) begin
                    sel_idx   = cand;
                    sel_valid = 1'b1;
                end
                cand = wrap_inc(cand);
            end
        end
    end

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_flit = bus.in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    // The output register can take a flit when empty or draining this cycle.
    assign space = ~out_valid_q | bus.out_ready;
    assign xfer  = space & sel_valid & ~rst;
    assign ready = xfer ? (NUM_IN'(1) << sel_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        timeout_d   = 1'b0;

        if (xfer) begin
            out_flit_d  = sel_flit;
            out_valid_d = 1'b1;
            grant_d     = sel_idx;
            idle_d      = '0;
            if (sel_flit[LAST_BIT]) begin
                state_d = ST_ARB;
                ptr_d   = wrap_inc(sel_idx);
            end else begin
                state_d = ST_LOCKED;
                owner_d = sel_idx;
            end
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            // Only an absent owner ages the lock; a valid owner stalled by
            // backpressure is making progress as far as the packet goes.
            if (state_q == ST_LOCKED && !bus.in_valid[owner_q]) begin
                if (idle_q == IDLE_W'(MAX_IDLE - 1)) begin
                    state_d   = ST_ARB;
                    ptr_d     = wrap_inc(owner_q);
                    timeout_d = 1'b1;
                    idle_d    = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_flit    = out_flit_q;
    assign bus.grant_id    = grant_q;
    assign bus.locked      = locked_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_mesh_port_arbiter.sv
// tb/tb_mesh_port_arbiter.sv - directed vector bench for mesh_port_arbiter
module tb_mesh_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mesh_port_arbiter_if #(.NUM_IN(5), .FLIT_W(64)) bus ();

    mesh_port_arbiter #(
        .NUM_IN(5), .FLIT_W(64), .LAST_BIT(62), .MAX_IDLE(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  valid;
        logic [4:0]  last;
        logic        ordy;
        logic        rst_v;
        logic [4:0]  exp_ready;
        logic        exp_ov;
        logic [2:0]  exp_gid;
        logic        exp_lk;
        logic        exp_to;
        logic [63:0] exp_flit;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [63:0] mf(input int src, input int step, input logic last);
        logic [63:0] f;
        f        = '0;
        f[62]    = last;
        f[15:8]  = 8'(step);
        f[7:0]   = 8'(src);
        return f;
    endfunction

    task automatic add(input logic [4:0] v, input logic [4:0] l, input logic o, input logic r,
                       input logic [4:0] er, input logic eov, input logic [2:0] eg,
                       input logic elk, input logic eto, input logic [63:0] ef);
        vec_t t;
        t.valid = v; t.last = l; t.ordy = o; t.rst_v = r;
        t.exp_ready = er; t.exp_ov = eov; t.exp_gid = eg;
        t.exp_lk = elk; t.exp_to = eto; t.exp_flit = ef;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [4:0] l, input logic o,
                         input logic r, input int step);
        logic [319:0] f;
        for (int j = 0; j < 5; j++) begin
            f[j*64 +: 64] = mf(j, step, l[j]);
        end
        bus.in_valid  = v;
        bus.in_flit   = f;
        bus.out_ready = o;
        rst           = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(5'h00, 5'h00, 1'b1, 1'b1, 0);

        // reset
        add(5'h1f, 5'h1f, 1, 1, 5'h00, 0, 0, 0, 0, 64'h0);
        // round robin, all last
        add(5'h1f, 5'h1f, 1, 0, 5'h01, 1, 0, 0, 0, mf(0, 1, 1));
        add(5'h1f, 5'h1f, 1, 0, 5'h02, 1, 1, 0, 0, mf(1, 2, 1));
        add(5'h1f, 5'h1f, 1, 0, 5'h04, 1, 2, 0, 0, mf(2, 3, 1));
        add(5'h1f, 5'h1f, 1, 0, 5'h08, 1, 3, 0, 0, mf(3, 4, 1));
        add(5'h1f, 5'h1f, 1, 0, 5'h10, 1, 4, 0, 0, mf(4, 5, 1));
        add(5'h1f, 5'h1f, 1, 0, 5'h01, 1, 0, 0, 0, mf(0, 6, 1));
        // idle drain: out_flit holds
        add(5'h00, 5'h00, 1, 0, 5'h00, 0, 0, 0, 0, mf(0, 6, 1));
        // packet lock: input 2 three flits while input 3 waits
        add(5'h0c, 5'h08, 1, 0, 5'h04, 1, 2, 1, 0, mf(2, 8, 0));
        add(5'h0c, 5'h08, 1, 0, 5'h04, 1, 2, 1, 0, mf(2, 9, 0));
        add(5'h0c, 5'h0c, 1, 0, 5'h04, 1, 2, 0, 0, mf(2, 10, 1));
        add(5'h08, 5'h08, 1, 0, 5'h08, 1, 3, 0, 0, mf(3, 11, 1));
        // ptr=4, only input 0 valid: wrap to 0, lock
        add(5'h01, 5'h00, 1, 0, 5'h01, 1, 0, 1, 0, mf(0, 12, 0));
        // backpressure for 4 cycles
        add(5'h03, 5'h00, 0, 0, 5'h00, 1, 0, 1, 0, mf(0, 12, 0));
        add(5'h03, 5'h00, 0, 0, 5'h00, 1, 0, 1, 0, mf(0, 12, 0));
        add(5'h03, 5'h00, 0, 0, 5'h00, 1, 0, 1, 0, mf(0, 12, 0));
        add(5'h03, 5'h00, 0, 0, 5'h00, 1, 0, 1, 0, mf(0, 12, 0));
        // release: drain and reload same cycle
        add(5'h03, 5'h01, 1, 0, 5'h01, 1, 0, 0, 0, mf(0, 17, 1));
        add(5'h02, 5'h02, 1, 0, 5'h02, 1, 1, 0, 0, mf(1, 18, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].ordy, vecs[i].rst_v, i);
            #1;
            chk($sformatf("v%0d.in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
            tick();
            chk($sformatf("v%0d.out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("v%0d.grant_id", i), 64'(bus.grant_id), 64'(vecs[i].exp_gid));
            chk($sformatf("v%0d.locked", i), 64'(bus.locked), 64'(vecs[i].exp_lk));
            chk($sformatf("v%0d.timeout", i), 64'(bus.timeout_err), 64'(vecs[i].exp_to));
            chk($sformatf("v%0d.out_flit", i), bus.out_flit, vecs[i].exp_flit);
        end

        // Watchdog: ptr=2, input 1 sends a non-last flit then goes quiet.
        begin
            int c;
            drive(5'h02, 5'h00, 1'b1, 1'b0, 40);
            #1;
            chk("wd.first_ready", 64'(bus.in_ready), 64'h02);
            tick();
            chk("wd.locked", 64'(bus.locked), 64'h1);
            chk("wd.grant", 64'(bus.grant_id), 64'h1);
            drive(5'h09, 5'h09, 1'b1, 1'b0, 41);
            c = 0;
            for (int k = 1; k <= 20; k++) begin
                tick();
                c = k;
                if (bus.timeout_err) break;
                if (bus.in_ready != 5'h00) break;
            end
            chk("wd.pulse_cycle", 64'(c), 64'd16);
            chk("wd.pulse", 64'(bus.timeout_err), 64'h1);
            chk("wd.unlocked", 64'(bus.locked), 64'h0);
            chk("wd.next_ready", 64'(bus.in_ready), 64'h08);
            tick();
            chk("wd.pulse_end", 64'(bus.timeout_err), 64'h0);
            chk("wd.next_grant", 64'(bus.grant_id), 64'h3);
            chk("wd.next_flit", bus.out_flit, mf(3, 41, 1));
        end

        // Reset mid-packet: input 2 locked, then rst.
        drive(5'h04, 5'h00, 1'b1, 1'b0, 50);
        tick();
        tick();
        chk("rs.locked_before", 64'(bus.locked), 64'h1);
        drive(5'h04, 5'h00, 1'b1, 1'b1, 51);
        #1;
        chk("rs.ready_in_rst", 64'(bus.in_ready), 64'h00);
        tick();
        chk("rs.out_valid", 64'(bus.out_valid), 64'h0);
        chk("rs.locked", 64'(bus.locked), 64'h0);
        chk("rs.grant", 64'(bus.grant_id), 64'h0);
        chk("rs.flit", bus.out_flit, 64'h0);
        drive(5'h11, 5'h11, 1'b1, 1'b0, 52);
        #1;
        chk("rs.restart_ready", 64'(bus.in_ready), 64'h01);
        tick();
        chk("rs.restart_grant", 64'(bus.grant_id), 64'h0);

        // Sparse: reset to ptr=0, then only input 4, then only input 0.
        drive(5'h00, 5'h00, 1'b1, 1'b1, 60);
        tick();
        drive(5'h10, 5'h10, 1'b1, 1'b0, 61);
        #1;
        chk("sp.ready4", 64'(bus.in_ready), 64'h10);
        tick();
        chk("sp.grant4", 64'(bus.grant_id), 64'h4);
        drive(5'h01, 5'h01, 1'b1, 1'b0, 62);
        #1;
        chk("sp.ready0", 64'(bus.in_ready), 64'h01);
        tick();
        chk("sp.grant0", 64'(bus.grant_id), 64'h0);
        chk("sp.flit0", bus.out_flit, mf(0, 62, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mesh_port_arbiter.md
Name: mesh_port_arbiter

Overview:
- Round-robin output-port arbiter for one direction (left/right/up/down/cpu) of a mesh router.
- Shares one 64-bit output link among NUM_IN input sources.
- Grants one flit per cycle into a registered output stage.
- Locks onto a winner until the packet's last flit passes; a watchdog breaks stalled locks.
- One instance per router output; five per router in the 3x3 mesh.

Parameters:
NUM_IN, 5, number of requesting inputs (left, right, up, down, cpu = indices 0..4)
FLIT_W, 64, flit width in bits
LAST_BIT, 62, flit bit index marking the last flit of a packet (1 = last)
MAX_IDLE, 16, consecutive cycles a locked owner may hold in_valid low before forced release

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
in_valid  input  NUM_IN  per-input flit valid
in_flit  input  NUM_IN*FLIT_W  packed flits; input i occupies bits [i*FLIT_W +: FLIT_W]
in_ready  output  NUM_IN  per-input accept, combinational, one-hot or zero
out_valid  output  1  output register holds a flit
out_flit  output  FLIT_W  registered output flit
out_ready  input  1  downstream accepts out_flit this cycle
grant_id  output  3  index of last granted input (registered)
locked  output  1  high while in LOCKED state
timeout_err  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (rst=1 at posedge) sets:
  - out_valid=0, out_flit=0, grant_id=0, locked=0, timeout_err=0
  - rr pointer ptr=0, state=ARB, idle counter=0
  - in_ready is forced to 0 while rst=1.
- Load condition:
  - space = ~out_valid | out_ready.
  - Transfer from input i occurs when in_valid[i] & in_ready[i].
  - in_ready[i] = space & (i == sel) & sel_valid.
- ARB state:
  - sel = first i with in_valid[i], searching ptr, ptr+1, ..., wrapping mod NUM_IN.
  - sel_valid = |in_valid.
- LOCKED state:
  - sel = owner; sel_valid = in_valid[owner].
  - All other in_ready are 0.
- On a transfer from input i:
  - out_flit <= flit_i, out_valid <= 1, grant_id <= i, idle counter <= 0.
  - If flit_i[LAST_BIT]=1: state <= ARB, ptr <= (i+1) mod NUM_IN.
  - If flit_i[LAST_BIT]=0: state <= LOCKED, owner <= i.
  - A single-flit packet (LAST_BIT=1) never enters LOCKED.
- No transfer but out_ready=1: out_valid <= 0; out_flit holds its value.
- Latency: input flit appears on out_flit the cycle after the transfer.
- Throughput: 1 flit/cycle with out_ready held high. Drain and reload in the same cycle replaces out_flit with no bubble.
- Backpressure: out_ready=0 with out_valid=1 keeps out_flit stable and all in_ready=0.
- Watchdog (LOCKED only):
  - The idle counter increments each cycle in_valid[owner]=0.
  - It does not count while the owner is valid but blocked by backpressure.
  - When the counter reaches MAX_IDLE: state <= ARB, ptr <= owner+1, timeout_err=1 for one cycle, counter <= 0.
  - Any owner transfer clears the counter.
- locked mirrors state==LOCKED (registered).
- Reset mid-packet: lock dropped, output register cleared, partial packet discarded. Upstream must resend.
- ptr is never equal to an index ≥ NUM_IN; wrap is explicit mod NUM_IN.

Test Plan:
1. Round-robin: all 5 in_valid high, every flit has bit62=1, out_ready=1.
   - Grants in order 0,1,2,3,4,0,...; grant_id follows one cycle later; one flit per cycle.
2. Packet lock: input 2 sends a 3-flit packet (bit62 = 0,0,1) while input 3 is continuously valid.
   - locked=1 after flit 1; in_ready[3]=0 until input 2's last flit transfers.
   - Next grant is 3, with no gap cycle.
3. Backpressure: out_valid=1, out_ready=0 for 4 cycles with inputs valid.
   - out_flit unchanged, all in_ready=0, idle counter unchanged.
   - Release out_ready: the next flit loads in the same cycle the old one drains.
4. Watchdog: input 1 sends a non-last flit, then drops in_valid.
   - After 16 idle cycles: timeout_err pulses for 1 cycle, locked=0, next grant searches from input 2.
5. Reset mid-packet: assert rst during a LOCKED 4-flit transfer.
   - Next cycle: out_valid=0, locked=0, grant_id=0, in_ready=0.
   - After rst deasserts, arbitration restarts from input 0.
6. Sparse requests: only input 4 valid, ptr=0.
   - Input 4 is granted; ptr wraps to 0; next sole request from input 0 is granted immediately.
